spi_copy_scheduler: RTL and testbench
=====================================

SPI_COPY_SCHEDULER -- requirements
Module: spi_copy_scheduler

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 16: bus-ownership settle time, in clocks, before the first and after the last flash operation.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 12_500_000: per-operation watchdog (500 ms at 25 MHz).
REQ-003 SHALL have port CLK_25M_CKMNG_MAIN_PLD, in, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port PWRGD_P1V2_MAX10_AUX_PLD_R, in, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports start (in, 1, one-clock request pulse) and abort (in, 1, level).
REQ-006 SHALL have ports src_start_addr, src_end_addr, dst_start_addr (in, 32 each) and switch_die_need (in, 1); all sampled at start.
REQ-007 SHALL have outputs busy, completed and error (1 each) and bytes_done (out, 32): bytes written so far.
REQ-008 SHALL have outputs BMC_SEL and PCH_SEL (1 each): 1 = flash routed to the FPGA.
REQ-009 SHALL have outputs die_sel (1) and the three engine handshakes: rd_req/rd_addr[31:0]/rd_len[8:0]/rd_done, er_req/er_addr[31:0]/er_done and wr_req/wr_addr[31:0]/wr_len[8:0]/wr_done (req/addr/len out, done in).

Function
REQ-010 SHALL implement states IDLE, GRANT, ERASE, ERASE_W, READ, READ_W, WRITE, WRITE_W, NEXT, RELEASE, DONE and ERR.
REQ-011 IDLE: on start, SHALL latch the inputs, set src_cur/dst_cur/bytes_done, raise busy, clear completed and error, and go to GRANT.
REQ-012 start while busy SHALL be ignored.
REQ-013 start with src_end_addr < src_start_addr SHALL go directly to ERR without asserting BMC_SEL or PCH_SEL.
REQ-014 GRANT: SHALL assert BMC_SEL and PCH_SEL, hold GUARD_CYCLES clocks, then go to ERASE if dst_cur[11:0]==0, else to READ.
REQ-015 Chunk length len SHALL be min(256 - dst_cur[7:0], src_end_addr - src_cur + 1), range 1..256, 9-bit.
REQ-016 ERASE: SHALL pulse er_req for 1 clock with er_addr = dst_cur, then go to ERASE_W; ERASE_W waits for er_done, then goes to READ.
REQ-017 READ: SHALL pulse rd_req for 1 clock with rd_addr = src_cur and rd_len = len, then go to READ_W; READ_W waits for rd_done.
REQ-018 WRITE: SHALL pulse wr_req for 1 clock with wr_addr = dst_cur and wr_len = len, then go to WRITE_W; WRITE_W waits for wr_done.
REQ-019 rd_addr, rd_len, er_addr, wr_addr and wr_len SHALL stay stable from the req pulse until the matching done.
REQ-020 NEXT: SHALL add len to src_cur, dst_cur and bytes_done (32-bit; wrap beyond 32'hFFFFFFFF is not supported).
REQ-021 NEXT: if src_cur > src_end_addr, SHALL go to RELEASE; else go to ERASE if dst_cur[11:0]==0, else to READ.
REQ-022 Die switch: when switch_die_need=1 and dst_cur crosses a 32 MiB boundary (dst_cur[24:0]==0), SHALL toggle die_sel in NEXT before the next request.
REQ-023 With switch_die_need=0, die_sel SHALL stay 0.
REQ-024 RELEASE: SHALL hold GUARD_CYCLES clocks, deassert BMC_SEL and PCH_SEL, then go to DONE.
REQ-025 DONE: SHALL pulse completed for 1 clock, drop busy and return to IDLE.
REQ-026 Watchdog: in each *_W state a counter SHALL run; reaching TIMEOUT_CYCLES SHALL go to ERR.
REQ-027 A done arriving in the same clock as the timeout SHALL win.
REQ-028 abort=1 in any busy state SHALL go to ERR on the next clock, with no further req pulses.
REQ-029 ERR: SHALL set error (sticky until the next start), then pass through RELEASE; completed SHALL NOT pulse and busy SHALL drop at exit.
REQ-030 A done input arriving outside its matching *_W state SHALL be ignored.

Reset
REQ-031 Reset low SHALL, at the next clock edge, force state IDLE and clear every output to 0 (busy, completed, error, bytes_done, BMC_SEL, PCH_SEL, die_sel, all req, addr and len outputs) and all counters.
REQ-032 Reset mid-operation SHALL release the flash immediately, without the guard time.

Structure
REQ-033 A shared package SHALL hold the state encoding, PAGE_BYTES=256, SECTOR_BYTES=4096, DIE_BYTES=32'h0200_0000 and the default GUARD_CYCLES and TIMEOUT_CYCLES.
REQ-034 The watchdog/guard counter SHALL be one sub-module, spi_op_timer (load, run, expire), reused for guard and timeout.

Verification
REQ-035 Copy src 0x0..0xB to dst 0x0: ERASE @0x0, READ len 12, WRITE len 12; completed pulses once, bytes_done=12, error=0.
REQ-036 Copy src 0x0..0x1FF to dst 0xF80: chunks 128 (dst 0xF80), then ERASE @0x1000, then 256 and 128; bytes_done=0x200.
REQ-037 switch_die_need=1, dst 0x1FFFF00, src length 0x200: die_sel toggles 0->1 before the request at dst 0x2000000.
REQ-038 er_done withheld: after TIMEOUT_CYCLES error=1, BMC_SEL and PCH_SEL fall after GUARD_CYCLES, completed stays 0.
REQ-039 abort in READ_W, then reset low mid-WRITE_W on a second run: ERR then RELEASE; after the reset all outputs are 0 in one clock.
REQ-040 start with src_end_addr < src_start_addr: error=1, BMC_SEL and PCH_SEL never asserted; a repeated start while busy leaves bytes_done unchanged.

Source files
------------

// File: rtl/spi_copy_scheduler_pkg.sv
// Shared types and constants for the SPI flash copy scheduler.
// Holds the state encoding, flash geometry and the default timings.
package spi_copy_scheduler_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GRANT,
    S_ERASE,
    S_ERASE_W,
    S_READ,
    S_READ_W,
    S_WRITE,
    S_WRITE_W,
    S_NEXT,
    S_RELEASE,
    S_DONE,
    S_ERR
  } state_e;

  localparam int unsigned PAGE_BYTES         = 256;
  localparam int unsigned SECTOR_BYTES       = 4096;
  localparam logic [31:0] DIE_BYTES          = 32'h0200_0000;
  localparam int unsigned GUARD_CYCLES_DEF   = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 12_500_000;

  // Bytes left in the destination page, capped by bytes left to copy.
  function automatic logic [8:0] chunk_len(
    input logic [31:0] src,
    input logic [31:0] src_end,
    input logic [31:0] dst
  );
    logic [31:0] rem;
    logic [8:0]  room;
    rem  = src_end - src;
    room = 9'(PAGE_BYTES) - {1'b0, dst[7:0]};
    if (rem < {23'd0, room}) chunk_len = rem[8:0] + 9'd1;
    else                     chunk_len = room;
  endfunction

endpackage

// File: rtl/spi_op_timer.sv
// Down-counter shared by the bus guard time and the per-op watchdog.
// expire rises on the last clock of a run window of 'limit' clocks.
module spi_op_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        run,
  input  logic [31:0] limit,
  output logic        expire
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                         cnt_d = limit;
    else if (run && cnt_q > 32'd1)    cnt_d = cnt_q - 32'd1;
  end

  assign expire = run && (cnt_q <= 32'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_copy_scheduler.sv
// Copies a flash range page by page: grant bus, erase sectors,
// read/write chunks, optional die switch, then release the bus.
module spi_copy_scheduler
  import spi_copy_scheduler_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES   = GUARD_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        CLK_25M_CKMNG_MAIN_PLD,
  input  logic        PWRGD_P1V2_MAX10_AUX_PLD_R,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] src_start_addr,
  input  logic [31:0] src_end_addr,
  input  logic [31:0] dst_start_addr,
  input  logic        switch_die_need,
  output logic        busy,
  output logic        completed,
  output logic        error,
  output logic [31:0] bytes_done,
  output logic        BMC_SEL,
  output logic        PCH_SEL,
  output logic        die_sel,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic [8:0]  rd_len,
  input  logic        rd_done,
  output logic        er_req,
  output logic [31:0] er_addr,
  input  logic        er_done,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [8:0]  wr_len,
  input  logic        wr_done
);

  localparam logic [31:0] SEC_MASK = 32'(SECTOR_BYTES - 1);
  localparam logic [31:0] DIE_MASK = DIE_BYTES - 32'd1;

  logic clk;
  logic rst_n;
  assign clk   = CLK_25M_CKMNG_MAIN_PLD;
  assign rst_n = PWRGD_P1V2_MAX10_AUX_PLD_R;

  state_e      state_q, state_d;
  logic [31:0] src_cur_q, src_end_q, dst_cur_q, bytes_q;
  logic [31:0] rd_addr_q, er_addr_q, wr_addr_q;
  logic [8:0]  len_q, rd_len_q, wr_len_q, len_now;
  logic        switch_q, busy_q, completed_q, error_q, sel_q, die_q;
  logic        rd_req_q, er_req_q, wr_req_q;
  logic        t_load, t_run, t_exp, sec_start, die_cross, abort_hit;
  logic [31:0] t_limit;

  assign len_now   = chunk_len(src_cur_q, src_end_q, dst_cur_q);
  assign sec_start = (dst_cur_q & SEC_MASK) == '0;
  assign die_cross = switch_q && ((dst_cur_q & DIE_MASK) == '0);
  assign abort_hit = abort && (state_q inside {S_GRANT, S_ERASE,
    S_ERASE_W, S_READ, S_READ_W, S_WRITE, S_WRITE_W, S_NEXT});

  // Timer runs only in timed states; every other state preloads it.
  assign t_run   = state_q inside {S_GRANT, S_RELEASE,
    S_ERASE_W, S_READ_W, S_WRITE_W};
  assign t_load  = !t_run;
  assign t_limit = (state_q inside {S_ERASE, S_READ, S_WRITE})
    ? 32'(TIMEOUT_CYCLES) : 32'(GUARD_CYCLES);

  spi_op_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (t_load),
    .run    (t_run),
    .limit  (t_limit),
    .expire (t_exp)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start)
          state_d = (src_end_addr < src_start_addr) ? S_ERR : S_GRANT;
      S_GRANT:   if (t_exp) state_d = sec_start ? S_ERASE : S_READ;
      S_ERASE:   state_d = S_ERASE_W;
      S_ERASE_W: if (er_done) state_d = S_READ;
                 else if (t_exp) state_d = S_ERR;
      S_READ:    state_d = S_READ_W;
      S_READ_W:  if (rd_done) state_d = S_WRITE;
                 else if (t_exp) state_d = S_ERR;
      S_WRITE:   state_d = S_WRITE_W;
      S_WRITE_W: if (wr_done) state_d = S_NEXT;
                 else if (t_exp) state_d = S_ERR;
      S_NEXT:
        if (src_cur_q > src_end_q) state_d = S_RELEASE;
        else state_d = sec_start ? S_ERASE : S_READ;
      S_RELEASE: if (t_exp) state_d = error_q ? S_IDLE : S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_RELEASE;
      default:   state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_cur_q   <= '0;
      src_end_q   <= '0;
      dst_cur_q   <= '0;
      bytes_q     <= '0;
      len_q       <= '0;
      switch_q    <= 1'b0;
      busy_q      <= 1'b0;
      completed_q <= 1'b0;
      error_q     <= 1'b0;
      sel_q       <= 1'b0;
      die_q       <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      er_req_q    <= 1'b0;
      er_addr_q   <= '0;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_len_q    <= '0;
    end else begin
      state_q     <= state_d;
      rd_req_q    <= state_d == S_READ;
      er_req_q    <= state_d == S_ERASE;
      wr_req_q    <= state_d == S_WRITE;
      completed_q <= state_d == S_DONE;
      if (state_q == S_IDLE && start) begin
        src_cur_q <= src_start_addr;
        src_end_q <= src_end_addr;
        dst_cur_q <= dst_start_addr;
        switch_q  <= switch_die_need;
        bytes_q   <= '0;
        busy_q    <= 1'b1;
        error_q   <= 1'b0;
        die_q     <= 1'b0;
      end
      if (state_q == S_IDLE && state_d == S_GRANT) sel_q <= 1'b1;
      if (state_q == S_RELEASE && state_d != S_RELEASE) sel_q <= 1'b0;
      if (state_d == S_ERASE) er_addr_q <= dst_cur_q;
      if (state_d == S_READ) begin
        rd_addr_q <= src_cur_q;
        rd_len_q  <= len_now;
        len_q     <= len_now;
      end
      if (state_d == S_WRITE) begin
        wr_addr_q <= dst_cur_q;
        wr_len_q  <= len_q;
      end
      if (state_d == S_NEXT) begin
        src_cur_q <= src_cur_q + 32'(len_q);
        dst_cur_q <= dst_cur_q + 32'(len_q);
        bytes_q   <= bytes_q + 32'(len_q);
      end
      if (state_q == S_NEXT && die_cross &&
          state_d inside {S_ERASE, S_READ})
        die_q <= !die_q;
      if (state_d == S_ERR)  error_q <= 1'b1;
      if (state_d == S_IDLE) busy_q  <= 1'b0;
    end
  end

  assign busy       = busy_q;
  assign completed  = completed_q;
  assign error      = error_q;
  assign bytes_done = bytes_q;
  assign BMC_SEL    = sel_q;
  assign PCH_SEL    = sel_q;
  assign die_sel    = die_q;
  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign rd_len     = rd_len_q;
  assign er_req     = er_req_q;
  assign er_addr    = er_addr_q;
  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_len     = wr_len_q;

endmodule

// File: tb/tb_spi_copy_scheduler.sv
// Directed bench for spi_copy_scheduler with a request-plan model
// and an engine responder that answers each req after a delay.
module tb_spi_copy_scheduler;

  localparam int G = 4;
  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] s_start = '0, s_end = '0, d_start = '0;
  logic        sw = 1'b0;
  logic        busy, completed, error, BMC_SEL, PCH_SEL, die_sel;
  logic [31:0] bytes_done, rd_addr, er_addr, wr_addr;
  logic [8:0]  rd_len, wr_len;
  logic        rd_req, er_req, wr_req;
  logic        rd_done = 1'b0, er_done = 1'b0, wr_done = 1'b0;

  spi_copy_scheduler #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .CLK_25M_CKMNG_MAIN_PLD     (clk),
    .PWRGD_P1V2_MAX10_AUX_PLD_R (rst_n),
    .start           (start),
    .abort           (abort),
    .src_start_addr  (s_start),
    .src_end_addr    (s_end),
    .dst_start_addr  (d_start),
    .switch_die_need (sw),
    .busy            (busy),
    .completed       (completed),
    .error           (error),
    .bytes_done      (bytes_done),
    .BMC_SEL         (BMC_SEL),
    .PCH_SEL         (PCH_SEL),
    .die_sel         (die_sel),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_len          (rd_len),
    .rd_done         (rd_done),
    .er_req          (er_req),
    .er_addr         (er_addr),
    .er_done         (er_done),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_len          (wr_len),
    .wr_done         (wr_done)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    int          len;
    logic        die;
  } op_t;

  op_t plan[$];
  op_t rd_op, wr_op;
  int  n_cmp = 0, n_bad = 0;
  int  n_compl = 0;
  bit  sel_seen = 0, er_hold = 0, stray = 0;
  int  dly = 3;
  int  rd_t = -1, er_t = -1, wr_t = -1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Expected request sequence: 0=erase 1=read 2=write.
  function automatic void build_plan(input logic [31:0] s,
    input logic [31:0] e, input logic [31:0] d, input bit swn);
    bit     die = 0;
    bit     more = 1;
    longint len;
    plan.delete();
    if (d % 4096 == 0) plan.push_back('{0, d, 0, die});
    while (more) begin
      len = 256 - longint'(d % 256);
      if (longint'(e) - longint'(s) + 1 < len)
        len = longint'(e) - longint'(s) + 1;
      plan.push_back('{1, s, int'(len), die});
      plan.push_back('{2, d, int'(len), die});
      s = s + 32'(len);
      d = d + 32'(len);
      if (s > e) more = 0;
      else begin
        if (swn && d % 32'h0200_0000 == 0) die = !die;
        if (d % 4096 == 0) plan.push_back('{0, d, 0, die});
      end
    end
  endfunction

  // Output checker and engine responder share one negedge process.
  initial forever begin
    op_t         op;
    int          kind;
    logic [31:0] addr;
    @(negedge clk);
    if (!rst_n) begin
      rd_t = -1; er_t = -1; wr_t = -1; stray = 0;
      rd_done = 0; er_done = 0; wr_done = 0;
    end else begin
      if (completed) n_compl++;
      if (BMC_SEL || PCH_SEL) sel_seen = 1;
      if (er_req || rd_req || wr_req) begin
        chk("req_onehot", int'(er_req) + int'(rd_req) + int'(wr_req), 1);
        chk("sel_at_req", {BMC_SEL, PCH_SEL}, 2'b11);
        if (plan.size() == 0) chk("extra_req", {er_req, rd_req, wr_req}, 0);
        else begin
          op = plan.pop_front();
          kind = er_req ? 0 : (rd_req ? 1 : 2);
          addr = er_req ? er_addr : (rd_req ? rd_addr : wr_addr);
          chk("req_kind", kind, op.kind);
          chk("req_addr", addr, op.addr);
          if (kind != 0) chk("req_len", rd_req ? rd_len : wr_len, op.len);
          chk("req_die", die_sel, op.die);
          if (rd_req) rd_op = op;
          if (wr_req) wr_op = op;
        end
      end
      if (rd_t >= 0) chk("rd_hold", {rd_addr, 23'd0, rd_len},
                         {rd_op.addr, 23'd0, 9'(rd_op.len)});
      if (wr_t >= 0) chk("wr_hold", {wr_addr, 23'd0, wr_len},
                         {wr_op.addr, 23'd0, 9'(wr_op.len)});
      rd_done = (rd_t == 0);
      er_done = (er_t == 0);
      wr_done = (wr_t == 0) || stray;
      stray = 0;
      if (rd_t >= 0) rd_t--;
      if (er_t >= 0) er_t--;
      if (wr_t >= 0) wr_t--;
      if (rd_req) begin rd_t = dly; stray = 1; end
      if (er_req && !er_hold) er_t = dly;
      if (wr_req) wr_t = dly;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] e,
                    input logic [31:0] d, input bit swn);
    s_start = s; s_end = e; d_start = d; sw = swn;
    n_compl = 0; sel_seen = 0;
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy !== 1'b0 && i < budget) begin tick(); i++; end
    if (i >= budget) chk("wait_idle_budget", busy, 0);
    tick(2);
  endtask

  task automatic wait_req(input int kind, input int budget);
    int i = 0;
    logic [2:0] want;
    want = 3'b100 >> kind;
    while ({er_req, rd_req, wr_req} != want && i < budget) begin
      tick(); i++;
    end
    if (i >= budget) chk("wait_req_budget", {er_req, rd_req, wr_req}, want);
  endtask

  function automatic logic any_out();
    return |{busy, completed, error, bytes_done, BMC_SEL, PCH_SEL,
             die_sel, rd_req, rd_addr, rd_len, er_req, er_addr,
             wr_req, wr_addr, wr_len};
  endfunction

  initial begin
    int n;
    tick(3);
    chk("reset_outputs", any_out(), 0);
    rst_n = 1; tick(2);

    // Single small chunk into an erased-sector boundary.
    build_plan(32'h0, 32'hB, 32'h0, 0);
    chk("plan1_size", plan.size(), 3);
    chk("plan1_len", plan[1].len, 12);
    go(32'h0, 32'hB, 32'h0, 0);
    chk("busy_after_start", busy, 1);
    wait_idle(500);
    chk("t1_completed", n_compl, 1);
    chk("t1_bytes", bytes_done, 32'd12);
    chk("t1_error", error, 0);
    chk("t1_plan_left", plan.size(), 0);
    chk("t1_sel_off", {BMC_SEL, PCH_SEL}, 0);

    // Page split across a sector, with an ignored start while busy.
    build_plan(32'h0, 32'h1FF, 32'hF80, 0);
    chk("plan2_size", plan.size(), 7);
    chk("plan2_erase", {plan[2].kind, plan[2].addr}, {32'd0, 32'h1000});
    go(32'h0, 32'h1FF, 32'hF80, 0);
    wait_req(0, 500);
    go(32'h0, 32'hB, 32'h0, 0);
    tick();
    chk("t2_bytes_mid", bytes_done, 32'h80);
    wait_idle(1000);
    chk("t2_bytes", bytes_done, 32'h200);
    chk("t2_plan_left", plan.size(), 0);
    chk("t2_error", error, 0);

    // Die switch at a 32 MiB destination boundary.
    build_plan(32'h0, 32'h1FF, 32'h1FF_FF00, 1);
    chk("plan3_size", plan.size(), 5);
    chk("plan3_die", {plan[2].addr, 31'd0, plan[2].die},
        {32'h0200_0000, 32'd1});
    go(32'h0, 32'h1FF, 32'h1FF_FF00, 1);
    wait_idle(1000);
    chk("t3_completed", n_compl, 1);
    chk("t3_die", die_sel, 1);
    chk("t3_bytes", bytes_done, 32'h200);
    chk("t3_plan_left", plan.size(), 0);

    // Done landing on the last watchdog clock still counts.
    dly = T - 1;
    build_plan(32'h0, 32'h3, 32'h10, 0);
    go(32'h0, 32'h3, 32'h10, 0);
    wait_idle(1000);
    dly = 3;
    chk("t4_done_at_limit_err", error, 0);
    chk("t4_done_at_limit_cmp", n_compl, 1);

    // Erase never answered: watchdog, then guarded release.
    er_hold = 1;
    build_plan(32'h0, 32'hF, 32'h2000, 0);
    go(32'h0, 32'hF, 32'h2000, 0);
    wait_req(0, 500);
    n = 0;
    while (error !== 1'b1 && n < 200) begin tick(); n++; end
    chk("t5_timeout_clks", n, T + 1);
    chk("t5_sel_held", {BMC_SEL, PCH_SEL}, 2'b11);
    n = 0;
    while (BMC_SEL !== 1'b0 && n < 200) begin tick(); n++; end
    chk("t5_release_clks", n, G + 1);
    wait_idle(200);
    er_hold = 0;
    chk("t5_error", error, 1);
    chk("t5_completed", n_compl, 0);
    chk("t5_pch_off", PCH_SEL, 0);

    // Abort while waiting on a read; no request may follow.
    build_plan(32'h0, 32'hFF, 32'h3000, 0);
    go(32'h0, 32'hFF, 32'h3000, 0);
    chk("t6_err_cleared", error, 0);
    wait_req(1, 500);
    tick(2);
    abort = 1;
    plan.delete();
    tick();
    abort = 0;
    wait_idle(200);
    chk("t6_error", error, 1);
    chk("t6_completed", n_compl, 0);
    chk("t6_sel_off", {BMC_SEL, PCH_SEL}, 0);

    // Reset mid-write drops everything in one clock.
    build_plan(32'h0, 32'hFF, 32'h4000, 0);
    go(32'h0, 32'hFF, 32'h4000, 0);
    wait_req(2, 500);
    tick();
    chk("t7_sel_before_rst", {BMC_SEL, PCH_SEL}, 2'b11);
    rst_n = 0;
    tick();
    chk("t7_reset_outputs", any_out(), 0);
    rst_n = 1;
    tick(2);

    // Reversed range: error without touching the bus select lines.
    plan.delete();
    go(32'h100, 32'hF, 32'h0, 0);
    chk("t8_busy", busy, 1);
    go(32'h0, 32'hB, 32'h0, 0);
    wait_idle(200);
    chk("t8_error", error, 1);
    chk("t8_sel_seen", sel_seen, 0);
    chk("t8_completed", n_compl, 0);
    chk("t8_bytes", bytes_done, 0);

    // A fresh start clears the sticky error.
    build_plan(32'h0, 32'hB, 32'h10, 0);
    go(32'h0, 32'hB, 32'h10, 0);
    chk("t9_err_cleared", error, 0);
    wait_idle(500);
    chk("t9_bytes", bytes_done, 32'd12);
    chk("t9_completed", n_compl, 1);
    chk("t9_plan_left", plan.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
